// File: rtl/heartbeat_pkg.sv
// Shared encodings for the LED heartbeat block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package heartbeat_pkg;

  // Pattern selection, as driven on the mode input.
  localparam logic [1:0] MODE_BLINK   = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_COUNT   = 2'd3;

  // Travel direction of the bouncing scan.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/heartbeat_multi_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV enabled cycles.
// Latency: tick is combinational from the prescaler count (first tick on the DIV-th edge).
// Backpressure: en=0 holds the count and masks tick; clr restarts the count at 0.
module tick_gen #(
  parameter int DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == PRE_LAST);

  // Count enabled cycles, wrapping on tick; a restart forces the count back to 0.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pre <= '0;
    end else if (clr || tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/heartbeat_multi.sv
// heartbeat_multi: N-channel LED heartbeat with blink, breathe, scan and count patterns.
// Latency: pattern state moves on each tick edge; LEDR and beat follow one edge later.
// Backpressure: none; en=0 freezes the pattern while the PWM ramp keeps running.
module heartbeat_multi
  import heartbeat_pkg::*;
#(
  parameter int NLED     = 10,
  parameter int DIV      = 500000,
  parameter int PWM_BITS = 8
) (
  input  logic            CLOCK_50,
  input  logic            KEY0,
  input  logic            en,
  input  logic [1:0]      mode,
  output logic [NLED-1:0] LEDR,
  output logic            beat
);
  localparam int SW     = PWM_BITS + 1;
  localparam int PERIOD = 2 ** SW;
  localparam int PHASE  = PERIOD / NLED;
  localparam int PW     = (NLED > 1) ? $clog2(NLED) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(NLED - 1);

  logic                tick;
  logic                restart;
  logic                adv;
  logic [1:0]          mode_q;
  logic [SW-1:0]       step;
  logic [PWM_BITS-1:0] pwm;
  logic [PW-1:0]       pos;
  dir_t                dir;
  logic [NLED-1:0]     cnt;
  logic                wrap_q;
  logic [NLED-1:0]     breathe_led;
  logic [NLED-1:0]     scan_led;
  logic [NLED-1:0]     led_next;

  // A mode change restarts every pattern; a tick landing in that cycle is dropped.
  assign restart = (mode != mode_q);
  assign adv     = tick && !restart;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .KEY0    (KEY0),
    .en      (en),
    .clr     (restart),
    .tick    (tick)
  );

  // Track the requested mode so a change can be detected one cycle later.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) mode_q <= MODE_BLINK;
    else       mode_q <= mode;
  end

  // Heartbeat phase and period-wrap flag; the flag feeds beat one edge later.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      step   <= '0;
      wrap_q <= 1'b0;
    end else if (restart) begin
      step   <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= adv && (step == '1);
      if (adv) step <= step + 1'b1;
    end
  end

  // PWM ramp free-runs every cycle so frozen breathe levels keep dimming correctly.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) pwm <= '0;
    else       pwm <= pwm + 1'b1;
  end

  // Bouncing scan position; turns around at both ends, parked at 0 with a single LED.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pos <= '0;
      dir <= DIR_UP;
    end else if (restart) begin
      pos <= '0;
      dir <= DIR_UP;
    end else if (adv && (NLED > 1)) begin
      if (dir == DIR_UP) begin
        if (pos == POS_LAST) begin
          dir <= DIR_DOWN;
          pos <= pos - 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          dir <= DIR_UP;
          pos <= pos + 1'b1;
        end else begin
          pos <= pos - 1'b1;
        end
      end
    end
  end

  // Binary counter shown directly on the LEDs in COUNT mode.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0)        cnt <= '0;
    else if (restart) cnt <= '0;
    else if (adv)     cnt <= cnt + 1'b1;
  end

  assign scan_led = NLED'(1) << pos;

  // Each channel reads the triangle wave at its own phase offset and compares with the ramp.
  for (genvar i = 0; i < NLED; i++) begin : g_breathe
    localparam logic [SW-1:0] OFFSET = SW'((i * PHASE) % PERIOD);
    logic [SW-1:0]       phase;
    logic [PWM_BITS-1:0] level;
    assign phase          = step + OFFSET;
    assign level          = phase[SW-1] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
    assign breathe_led[i] = (pwm < level);
  end

  // Select the active pattern for the LED register.
  always_comb begin
    led_next = '0;
    case (mode_q)
      MODE_BLINK:   led_next = {NLED{step[SW-1]}};
      MODE_BREATHE: led_next = breathe_led;
      MODE_SCAN:    led_next = scan_led;
      MODE_COUNT:   led_next = cnt;
      default:      led_next = '0;
    endcase
  end

  // Registered LED drive and beat pulse; a restart blanks the LEDs for one edge.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      LEDR <= '0;
      beat <= 1'b0;
    end else if (restart) begin
      LEDR <= '0;
      beat <= 1'b0;
    end else begin
      LEDR <= led_next;
      beat <= wrap_q;
    end
  end

endmodule

// File: tb/tb_heartbeat_multi.sv
// Directed bench for heartbeat_multi with a small-parameter configuration.
// Expected LED/beat values are queued as stimulus is applied and popped per cycle.
// Breathe duty is measured per 4-cycle PWM window and compared with a triangle model.
module tb_heartbeat_multi;
  localparam int NLED     = 4;
  localparam int DIV      = 4;
  localparam int PWM_BITS = 2;
  localparam int PERIOD   = 1 << (PWM_BITS + 1);
  localparam int HALF     = 1 << PWM_BITS;
  localparam int PHASE    = PERIOD / NLED;
  localparam int WIN      = 1 << PWM_BITS;

  logic            clk = 1'b0;
  logic            key0;
  logic            en;
  logic [1:0]      mode;
  logic [NLED-1:0] ledr;
  logic            beat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NLED-1:0] led_q[$];
  logic            beat_q[$];
  logic [7:0]      duty_q[$];

  heartbeat_multi #(
    .NLED    (NLED),
    .DIV     (DIV),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .CLOCK_50(clk),
    .KEY0    (key0),
    .en      (en),
    .mode    (mode),
    .LEDR    (ledr),
    .beat    (beat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_led(input logic [NLED-1:0] v, input int n);
    for (int i = 0; i < n; i++) led_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    logic [NLED-1:0] e;
    logic            b;
    int              c;
    c = 0;
    while (led_q.size() > 0) begin
      cyc();
      c++;
      e = led_q.pop_front();
      check($sformatf("%s_led_c%0d", tag, c), 32'(ledr), 32'(e));
      if (beat_q.size() > 0) begin
        b = beat_q.pop_front();
        check($sformatf("%s_beat_c%0d", tag, c), 32'(beat), 32'(b));
      end
    end
  endtask

  function automatic int level(input int p);
    int q;
    q = p % PERIOD;
    return (q < HALF) ? q : (PERIOD - 1 - q);
  endfunction

  initial begin
    logic [7:0] d;
    int         on_cnt [NLED];
    int         m;

    key0 = 1'b0;
    en   = 1'b1;
    mode = 2'd0;

    // Reset state held for a few cycles.
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("reset_led", 32'(ledr), 32'd0);
      check("reset_beat", 32'(beat), 32'd0);
    end
    key0 = 1'b1;

    // BLINK: 16 cycles off, 16 on, beat once per 32 cycles aligned with the fall.
    for (int k = 1; k <= 80; k++) begin
      led_q.push_back((((k - 1) / 16) % 2 == 1) ? 4'hF : 4'h0);
      beat_q.push_back((k % 32 == 1) && (k > 1));
    end
    drain("blink");

    // SCAN: restart blanks the LEDs, then one position per tick.
    mode = 2'd2;
    push_led(4'b0000, 1);
    push_led(4'b0001, 4);
    push_led(4'b0010, 4);
    push_led(4'b0100, 4);
    push_led(4'b1000, 4);
    push_led(4'b0100, 4);
    push_led(4'b0010, 4);
    push_led(4'b0001, 4);
    push_led(4'b0010, 4);
    drain("scan");

    // Switch to COUNT with the scan at position 2; count restarts from 0.
    mode = 2'd3;
    push_led(4'b0000, 5);
    for (int v = 1; v <= 16; v++) push_led(4'(v), 4);
    drain("count");

    // Freeze: value holds, no beat; resumes DIV cycles after en returns.
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      led_q.push_back(4'b0001);
      beat_q.push_back(1'b0);
    end
    drain("freeze");
    en = 1'b1;
    push_led(4'b0001, 4);
    push_led(4'b0010, 1);
    drain("resume");

    // BREATHE: per-step on-cycle count per channel follows the phased triangle.
    mode = 2'd1;
    for (int s = 0; s < 8; s++) begin
      d = '0;
      for (int i = 0; i < NLED; i++) d[2*i +: 2] = 2'(level(s + i * PHASE));
      duty_q.push_back(d);
    end
    cyc();
    check("breathe_restart_led", 32'(ledr), 32'd0);
    m = 0;
    while (duty_q.size() > 0) begin
      for (int i = 0; i < NLED; i++) on_cnt[i] = 0;
      for (int j = 0; j < WIN; j++) begin
        cyc();
        for (int i = 0; i < NLED; i++) on_cnt[i] += int'(ledr[i]);
      end
      d = duty_q.pop_front();
      for (int i = 0; i < NLED; i++)
        check($sformatf("breathe_ch%0d_step%0d", i, m), 32'(on_cnt[i]), 32'(d[2*i +: 2]));
      m++;
    end

    // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
    #2;
    key0 = 1'b0;
    #1;
    check("async_rst_led", 32'(ledr), 32'd0);
    check("async_rst_beat", 32'(beat), 32'd0);
    cyc();
    check("async_rst_hold_led", 32'(ledr), 32'd0);
    key0 = 1'b1;
    cyc();
    check("post_rst_restart_led", 32'(ledr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
